// File: rtl/vga_scanout.sv
// VGA 640x480@60 scanout: raster counters, pixelStore read coordinates, palette
// expansion and a 5x5 hollow brush cursor, with registered sync/colour pins.
module vga_scanout #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [9:0] cursorX,
    input  logic [9:0] cursorY,
    output logic [9:0] rx,
    output logic [9:0] ry,
    input  logic [2:0] colorCode,
    output logic       frameStart,
    output logic       hsync,
    output logic       vsync,
    output logic [3:0] red,
    output logic [3:0] green,
    output logic [3:0] blue
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam logic [9:0] H_LAST    = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST    = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS     = 10'(H_ACTIVE);
    localparam logic [9:0] V_VIS     = 10'(V_ACTIVE);
    localparam logic [9:0] HS_FIRST  = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_LAST   = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [9:0] VS_FIRST  = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_LAST   = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

    logic [9:0] hcnt, vcnt;
    logic [9:0] shadowX, shadowY;
    logic signed [10:0] dx, dy;
    logic nearX, nearY, edgeX, edgeY, hitNow, activeNow, hsRawNow, vsRawNow;
    logic active1, hit1, hsRaw1, vsRaw1;
    logic [2:0] pixColor;

    always_ff @(posedge clk) begin
        if (!reset) begin
            hcnt <= '0;
            vcnt <= '0;
        end else if (hcnt == H_LAST) begin
            hcnt <= '0;
            vcnt <= (vcnt == V_LAST) ? 10'd0 : vcnt + 10'd1;
        end else begin
            hcnt <= hcnt + 10'd1;
        end
    end

    assign rx = hcnt;
    assign ry = vcnt;
    // Gated by reset so no pulse appears while the counters are held at zero.
    assign frameStart = reset && (hcnt == 10'd0) && (vcnt == 10'd0);

    always_ff @(posedge clk) begin
        if (!reset) begin
            shadowX <= 10'h3FF;
            shadowY <= 10'h3FF;
        end else if (frameStart) begin
            shadowX <= cursorX;
            shadowY <= cursorY;
        end
    end

    // Signed distance without wrap, so the box is clipped at screen edges.
    always_comb begin
        dx        = $signed({1'b0, hcnt}) - $signed({1'b0, shadowX});
        dy        = $signed({1'b0, vcnt}) - $signed({1'b0, shadowY});
        nearX     = (dx >= -11'sd2) && (dx <= 11'sd2);
        nearY     = (dy >= -11'sd2) && (dy <= 11'sd2);
        edgeX     = (dx == 11'sd2) || (dx == -11'sd2);
        edgeY     = (dy == 11'sd2) || (dy == -11'sd2);
        hitNow    = nearX && nearY && (edgeX || edgeY);
        activeNow = (hcnt < H_VIS) && (vcnt < V_VIS);
        hsRawNow  = !((hcnt >= HS_FIRST) && (hcnt <= HS_LAST));
        vsRawNow  = !((vcnt >= VS_FIRST) && (vcnt <= VS_LAST));
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            active1 <= 1'b0;
            hit1    <= 1'b0;
            hsRaw1  <= 1'b1;
            vsRaw1  <= 1'b1;
        end else begin
            active1 <= activeNow;
            hit1    <= hitNow;
            hsRaw1  <= hsRawNow;
            vsRaw1  <= vsRawNow;
        end
    end

    assign pixColor = hit1 ? ~colorCode : colorCode;

    always_ff @(posedge clk) begin
        if (!reset) begin
            hsync <= 1'b1;
            vsync <= 1'b1;
            red   <= '0;
            green <= '0;
            blue  <= '0;
        end else begin
            hsync <= hsRaw1;
            vsync <= vsRaw1;
            red   <= active1 ? {4{pixColor[2]}} : 4'h0;
            green <= active1 ? {4{pixColor[1]}} : 4'h0;
            blue  <= active1 ? {4{pixColor[0]}} : 4'h0;
        end
    end
endmodule

// File: tb/tb_vga_scanout.sv
// Scoreboard bench for vga_scanout on a reduced raster; a cycle-count reference
// model pushes expected pins, a separate monitor pops and compares them.
module tb_vga_scanout;
    localparam int HA = 160, HF = 8, HS = 16, HB = 16;
    localparam int VA = 60, VF = 3, VS = 2, VB = 5;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic [9:0] cursorX = 10'h3FF, cursorY = 10'h3FF;
    logic [2:0] colorCode = 3'b000;
    logic [9:0] rx, ry;
    logic frameStart, hsync, vsync;
    logic [3:0] red, green, blue;

    vga_scanout #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
    ) dut (
        .clk(clk), .reset(reset), .cursorX(cursorX), .cursorY(cursorY),
        .rx(rx), .ry(ry), .colorCode(colorCode), .frameStart(frameStart),
        .hsync(hsync), .vsync(vsync), .red(red), .green(green), .blue(blue)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       hs;
        logic       vs;
        logic [11:0] rgb;
    } pins_t;

    pins_t pinQ[$];
    int checks = 0, errors = 0;
    int mode = 0, seedK = 0;
    int n = 0, mh = 0, mv = 0, shX = 1023, shY = 1023;
    logic [9:0] expRx = '0, expRy = '0;
    logic expFs = 1'b0;
    logic rstS = 1'b0;
    logic [2:0] pendColor;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [2:0] pixAt(input int h, input int v);
        case (mode)
            0: return (h == 100 && v == 30) ? 3'b100 : 3'b000;
            1: return 3'b111;
            2: return 3'b000;
            default: return 3'((h * 7 + v * 13 + seedK) & 7);
        endcase
    endfunction

    function automatic pins_t resetPins();
        pins_t p;
        p.hs = 1'b1; p.vs = 1'b1; p.rgb = 12'h000;
        return p;
    endfunction

    // pixelStore stand-in: one cycle of read latency
    initial forever begin
        @(negedge clk);
        pendColor = pixAt(int'(rx), int'(ry));
        @(posedge clk);
        #1 colorCode = pendColor;
    end

    initial forever begin
        @(posedge clk);
        rstS = reset;
    end

    // Reference model: raster position from cycles elapsed since reset
    initial forever begin
        pins_t p;
        int adx, ady;
        logic [2:0] c;
        bit act, hit;
        @(negedge clk);
        if (!rstS) begin
            n = 0; shX = 1023; shY = 1023;
            pinQ.delete();
            pinQ.push_back(resetPins());
            pinQ.push_back(resetPins());
        end
        mh = n % HT;
        mv = (n / HT) % VT;
        expRx = 10'(mh);
        expRy = 10'(mv);
        expFs = reset && mh == 0 && mv == 0;
        act = (mh < HA) && (mv < VA);
        adx = (mh > shX) ? mh - shX : shX - mh;
        ady = (mv > shY) ? mv - shY : shY - mv;
        hit = adx <= 2 && ady <= 2 && (adx == 2 || ady == 2);
        c = pixAt(mh, mv);
        if (hit) c = ~c;
        p.rgb = act ? {{4{c[2]}}, {4{c[1]}}, {4{c[0]}}} : 12'h000;
        p.hs = !(mh >= HA + HF && mh < HA + HF + HS);
        p.vs = !(mv >= VA + VF && mv < VA + VF + VS);
        pinQ.push_back(p);
        if (expFs) begin
            shX = int'(cursorX);
            shY = int'(cursorY);
        end
        n++;
    end

    // Monitor: compares DUT outputs against the scoreboard every cycle
    initial begin
        pins_t e;
        int cyc = 0, lastFs = -1, lowRun = 0;
        forever begin
            @(negedge clk);
            #2;
            cyc++;
            chk("rx", 32'(rx), 32'(expRx));
            chk("ry", 32'(ry), 32'(expRy));
            chk("frameStart", 32'(frameStart), 32'(expFs));
            if (pinQ.size() == 0) begin
                chk("scoreboard_empty", 32'(1), 32'(0));
            end else begin
                e = pinQ.pop_front();
                chk("hsync", 32'(hsync), 32'(e.hs));
                chk("vsync", 32'(vsync), 32'(e.vs));
                chk("rgb", 32'({red, green, blue}), 32'(e.rgb));
            end
            if (!rstS) lastFs = -1;
            if (frameStart === 1'b1) begin
                if (lastFs >= 0) chk("frame_period", 32'(cyc - lastFs), 32'(HT * VT));
                lastFs = cyc;
            end
            if (hsync === 1'b0) lowRun++;
            else begin
                if (lowRun > 0) chk("hsync_width", 32'(lowRun), 32'(HS));
                lowRun = 0;
            end
        end
    end

    task automatic waitPos(input int h, input int v);
        int budget = 0;
        forever begin
            @(negedge clk);
            #3;
            if (mh == h && mv == v) break;
            budget++;
            if (budget > 3 * HT * VT / 2) begin
                chk("wait_timeout", 32'(budget), 32'(0));
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b0;
        repeat (4) @(posedge clk);
        #1 reset = 1'b1;
        mode = 0;
        waitPos(0, 40);
        cursorX = 10'd100; cursorY = 10'd50; mode = 2;
        waitPos(0, 20);
        cursorX = 10'd200;
        waitPos(0, 65);
        mode = 1;
        waitPos(0, 65);
        cursorX = 10'd0; cursorY = 10'd10; mode = 2;
        waitPos(0, 65);
        mode = 3;
        seedK = int'($urandom_range(0, 7));
        for (int i = 0; i < 6; i++) begin
            waitPos(int'($urandom_range(0, HT - 1)), int'($urandom_range(0, VT - 1)));
            cursorX = ($urandom_range(0, 5) == 0) ? 10'h3FF : 10'($urandom_range(0, HT + 3));
            cursorY = ($urandom_range(0, 5) == 0) ? 10'h3FF : 10'($urandom_range(0, VT + 3));
        end
        waitPos(119, 10);
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        repeat (1000) @(posedge clk);
        #4;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/vga_scanout.md
# vga_scanout

Display-side reader for the `pixelStore` frame buffer. The block generates 640x480 at 60 Hz VGA timing from the pixel clock and drives the `rx`/`ry` read coordinates into `pixelStore`. It takes the returned `colorCode`, maps it to 4-bit-per-channel RGB and overlays a brush cursor. Its outputs are registered sync and colour signals that go to the board's VGA pins.

## Interface
Parameters:
- `H_ACTIVE`, 640, visible pixels per line
- `H_FP`, 16, horizontal front porch
- `H_SYNC`, 96, horizontal sync width
- `H_BP`, 48, horizontal back porch
- `V_ACTIVE`, 480, visible lines
- `V_FP`, 10, vertical front porch
- `V_SYNC`, 2, vertical sync width
- `V_BP`, 33, vertical back porch

Ports:
- `clk`  in  1  pixel clock, 25.175 MHz
- `reset`  in  1  synchronous, active-low reset
- `cursorX`  in  10  cursor centre, screen x
- `cursorY`  in  10  cursor centre, screen y
- `rx`  out  10  read x to `pixelStore` (equals hcnt)
- `ry`  out  10  read y to `pixelStore` (equals vcnt)
- `colorCode`  in  3  pixel colour from `pixelStore`, valid 1 cycle after `rx`/`ry`
- `frameStart`  out  1  one-cycle pulse when hcnt=0 and vcnt=0, aligned with `rx`/`ry`
- `hsync`  out  1  active-low horizontal sync, registered
- `vsync`  out  1  active-low vertical sync, registered
- `red`, `green`, `blue`  out  4 each  colour to DAC, registered

## Operation
- **Counters.**
  - hcnt runs 0..799 (H_TOTAL = sum of the H_* parameters) and wraps to 0.
  - vcnt increments when hcnt wraps, runs 0..524, and wraps to 0.
  - `rx` = hcnt and `ry` = vcnt, combinationally from the counter registers, always, including during blanking. `pixelStore` handles out-of-range coordinates.
- **Sync generation.**
  - hsync is active (0) when hcnt is in [656, 751].
  - vsync is active (0) when vcnt is in [490, 491].
  - active = (hcnt < 640) and (vcnt < 480).
- **Cursor shadow registers.**
  - `cursorX`/`cursorY` are latched into shadow registers only in the cycle `frameStart`=1.
  - A cursor move therefore takes effect at the next frame, never mid-frame.
- **Cursor hit.**
  - dx = hcnt − shadowX and dy = vcnt − shadowY, computed 11-bit signed.
  - hit when |dx| ≤ 2, |dy| ≤ 2, and (|dx| = 2 or |dy| = 2), i.e. a 5x5 hollow box.
  - No wrap: a cursor at an edge is clipped, with no pixels drawn on the opposite edge.
- **Palette.**
  - c = ~colorCode when hit, else colorCode.
  - red = {4{c[2]}}, green = {4{c[1]}}, blue = {4{c[0]}}.
  - When not active, RGB = 0 regardless of `colorCode` or hit.
- **Pipeline.**
  - Stage 1 (cycle t+1): registers active, hit, raw hsync and raw vsync computed from the counters at cycle t. `colorCode` for (`rx`, `ry`) at cycle t also arrives at t+1.
  - Stage 2 (cycle t+2): registers the pin outputs from the stage-1 values and `colorCode`.
- **Reset** (reset=0 at a rising edge).
  - Counters go to 0 and both pipeline stages clear.
  - hsync=1, vsync=1, RGB=0, frameStart=0.
  - Shadow cursor = (1023, 1023), i.e. off-screen.
- **Reset mid-frame.** Same behaviour as above; there is no partial line completion.

## Timing
- `rx`/`ry` to pins: 2 cycles. Syncs and RGB are delayed identically, so hcnt=0 appears at the pins 2 cycles after `rx`=0.
- `frameStart` is asserted in the first cycle after reset deasserts, then every 420000 cycles (800 x 525).
- Line period: 800 cycles. Frame period: 525 lines.
- Pin-level hsync falls 658 cycles after the `rx`=0 cycle and stays low for exactly 96 cycles.
- Pin-level vsync is low for exactly 1600 cycles per frame.

## Test plan
1. **Reset release and counter wrap.**
   - Stimulus: release reset and run.
   - Required: `frameStart`=1 in the first cycle after release; `rx` steps 0..799 then returns to 0 while `ry` goes 0→1; next `frameStart` exactly 420000 cycles later.
2. **Sync placement.**
   - Stimulus: run one full frame.
   - Required: hsync low for exactly 96 consecutive cycles, starting 658 cycles after `rx`=0; vsync low exactly during the lines where `ry` was 490 and 491 (delayed 2 cycles); both high everywhere else.
3. **Pixel alignment.**
   - Stimulus: pixelStore model with 1-cycle latency returns 3'b100 only for (300, 300), 3'b000 elsewhere.
   - Required: exactly one pin cycle with red=F, green=0, blue=0, occurring 2 cycles after `rx`=300, `ry`=300.
4. **Blanking.**
   - Stimulus: force `colorCode`=3'b111 constantly.
   - Required: RGB = FFF on all active pixels; RGB = 000 for hcnt 640..799 and for vcnt 480..524.
5. **Cursor overlay and frame latching.**
   - Stimulus: `cursorX`=100, `cursorY`=50, `colorCode`=000.
   - Required in the next frame: white at (98, 48), (102, 50) and (100, 52); black at (100, 50) and (99, 49).
   - Stimulus: change `cursorX` to 200 mid-frame.
   - Required: the box stays at x=100 until the following frame.
   - Stimulus: `cursorX`=0.
   - Required: no cursor pixels at x=798 or x=799.
6. **Reset mid-line.**
   - Stimulus: assert reset while `rx`=400, `ry`=10.
   - Required: next cycle `rx`=0, `ry`=0, hsync=1, vsync=1, RGB=0.
   - Stimulus: release reset.
   - Required: `frameStart` pulses immediately.
